// File: rtl/and22_sweep_checker_pkg.sv
// and22_sweep_checker_pkg
// Shared definitions for the and22 sweep checker:
//   - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - default operand width and hold length
//   - helper that sizes the hold counter so HOLD=1 still gets a 1-bit counter
package and22_sweep_checker_pkg;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_HOLD  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..hold-1; never less than one bit.
    function automatic int hold_bits(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/and22_sweep_checker_hold_counter.sv
// sweep_hold_counter
// Owns the vector index and the per-vector hold counter of a sweep.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_clear       : restart the sweep at vector 0, hold count 0
//   i_enable      : advance the hold counter this cycle (high while running)
//   o_vec         : current {a,b} vector index
//   o_sample      : high in the last cycle of the current hold window
//   o_last        : current vector is the terminal one (all ones)
module sweep_hold_counter
    import and22_sweep_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_enable,
    output logic [2*WIDTH-1:0] o_vec,
    output logic               o_sample,
    output logic               o_last
);

    localparam int VW = 2 * WIDTH;
    localparam int HW = hold_bits(HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    logic [HW-1:0] r_hold_cnt;
    logic [VW-1:0] r_vec;
    logic          w_sample;
    logic          w_last;

    assign w_sample = i_enable && (r_hold_cnt == HOLD_LAST);
    assign w_last   = &r_vec;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_cnt <= '0;
            r_vec      <= '0;
        end else if (i_clear) begin
            r_hold_cnt <= '0;
            r_vec      <= '0;
        end else if (i_enable) begin
            if (w_sample) begin
                r_hold_cnt <= '0;
                // The terminal vector ends the sweep, so the index never wraps.
                if (!w_last) begin
                    r_vec <= r_vec + VW'(1);
                end
            end else begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end
        end
    end

    assign o_vec    = r_vec;
    assign o_sample = w_sample;
    assign o_last   = w_last;

endmodule

// File: rtl/and22_sweep_checker.sv
// and22_sweep_checker
// Clocked stimulus-and-check stage for a WIDTH-bit AND gate. Drives every
// {a,b} combination in order, holding each for HOLD cycles, samples the
// gate's z in the last cycle of each hold window and compares it with a&b.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start          : one-cycle pulse; accepted only in IDLE, otherwise dropped
//   z              : gate result
//   a, b           : registered operands driven to the gate
//   busy           : high for the whole sweep (2^(2*WIDTH)*HOLD cycles)
//   done           : one-cycle pulse the cycle after the final sample
//   err_cnt        : mismatching vectors in the current/last sweep
//   err_flag       : any mismatch seen in the current/last sweep
//   first_err_vec  : {a,b} of the first mismatch (meaningful when err_flag=1)
// Handshake: start is a level sampled at the rising edge; it is honoured
// only when the FSM is in IDLE and there is no acknowledge other than busy
// rising on the next cycle. Results stay put until the next accepted start.
module and22_sweep_checker
    import and22_sweep_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   z,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   err_cnt,
    output logic               err_flag,
    output logic [2*WIDTH-1:0] first_err_vec
);

    localparam int VW = 2 * WIDTH;

    state_t          r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic [VW:0]      r_err_cnt;
    logic             r_err_flag;
    logic [VW-1:0]    r_first_err_vec;

    logic [VW-1:0]    w_vec;
    logic [VW-1:0]    w_vec_next;
    logic             w_sample;
    logic             w_last;
    logic             w_clear;
    logic             w_enable;
    logic             w_mismatch;

    assign w_clear    = (r_state == ST_IDLE) && start;
    assign w_enable   = (r_state == ST_RUN);
    assign w_vec_next = w_vec + VW'(1);
    // Golden value comes from the registered operands actually on the gate.
    assign w_mismatch = w_sample && (z != (r_a & r_b));

    sweep_hold_counter #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) u_hold_counter (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_vec    (w_vec),
        .o_sample (w_sample),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_a             <= '0;
            r_b             <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err_cnt       <= '0;
            r_err_flag      <= 1'b0;
            r_first_err_vec <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state         <= ST_RUN;
                        r_busy          <= 1'b1;
                        r_a             <= '0;
                        r_b             <= '0;
                        r_err_cnt       <= '0;
                        r_err_flag      <= 1'b0;
                        r_first_err_vec <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_sample) begin
                        if (w_mismatch) begin
                            r_err_cnt <= r_err_cnt + (VW+1)'(1);
                            if (!r_err_flag) begin
                                r_err_flag      <= 1'b1;
                                r_first_err_vec <= w_vec;
                            end
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_a     <= '0;
                            r_b     <= '0;
                        end else begin
                            // Operands move with the counter so {a,b} always equals vec.
                            {r_a, r_b} <= w_vec_next;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign a             = r_a;
    assign b             = r_b;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_cnt       = r_err_cnt;
    assign err_flag      = r_err_flag;
    assign first_err_vec = r_first_err_vec;

endmodule

// File: tb/tb_and22_sweep_checker.sv
// tb_and22_sweep_checker
// Two checkers: one with HOLD=10 in front of a faultable AND gate model,
// one with HOLD=1 in front of a correct gate.
module tb_and22_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // HOLD=10 instance
    logic       rst, start;
    logic [1:0] a, b, z;
    logic       busy, done, err_flag;
    logic [4:0] err_cnt;
    logic [3:0] first_err_vec;
    logic [1:0] sa0, sa1;   // stuck-at-0 / stuck-at-1 masks of the gate model

    assign z = ((a & b) & ~sa0) | sa1;

    and22_sweep_checker #(.WIDTH(2), .HOLD(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .z             (z),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt),
        .err_flag      (err_flag),
        .first_err_vec (first_err_vec)
    );

    // HOLD=1 instance
    logic       rst1, start1;
    logic [1:0] a1, b1, z1;
    logic       busy1, done1, err_flag1;
    logic [4:0] err_cnt1;
    logic [3:0] first_err_vec1;

    assign z1 = a1 & b1;

    and22_sweep_checker #(.WIDTH(2), .HOLD(1)) dut1 (
        .clk           (clk),
        .rst           (rst1),
        .start         (start1),
        .z             (z1),
        .a             (a1),
        .b             (b1),
        .busy          (busy1),
        .done          (done1),
        .err_cnt       (err_cnt1),
        .err_flag      (err_flag1),
        .first_err_vec (first_err_vec1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk all 16 {a,b} pairs, apply the gate faults, count misses.
    task automatic model(input logic [1:0] m0, input logic [1:0] m1,
                         output int cnt, output bit flag, output logic [3:0] first);
        logic [1:0] aa, bb, g, zz;
        cnt = 0; flag = 0; first = '0;
        for (int v = 0; v < 16; v++) begin
            aa = 2'(v / 4);
            bb = 2'(v % 4);
            g  = aa & bb;
            zz = (g & ~m0) | m1;
            if (zz != g) begin
                if (!flag) first = 4'(v);
                flag = 1;
                cnt++;
            end
        end
    endtask

    task automatic sweep(input string tag, input logic [1:0] m0, input logic [1:0] m1,
                         input int delay, input bit extra_starts);
        int         cnt;
        bit         flag;
        logic [3:0] first;
        model(m0, m1, cnt, flag, first);
        sa0 = m0;
        sa1 = m1;
        repeat (delay) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/cleared_cnt"}, err_cnt, 0);
        chk({tag, "/cleared_flag"}, err_flag, 0);
        for (int i = 0; i < 160; i++) begin
            chk({tag, "/busy"}, busy, 1);
            chk({tag, "/done_low"}, done, 0);
            chk({tag, "/ab"}, {a, b}, i / 10);
            if (extra_starts && i == 40) start = 1'b1;
            if (extra_starts && i == 41) start = 1'b0;
            @(negedge clk);
        end
        chk({tag, "/end_busy"}, busy, 0);
        chk({tag, "/end_done"}, done, 1);
        chk({tag, "/err_cnt"}, err_cnt, cnt);
        chk({tag, "/err_flag"}, err_flag, flag);
        if (flag) chk({tag, "/first_err_vec"}, first_err_vec, first);
        if (extra_starts) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/post_done"}, done, 0);
        chk({tag, "/post_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, "/idle_busy"}, busy, 0);
        chk({tag, "/hold_cnt"}, err_cnt, cnt);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sa0 = 2'b00; sa1 = 2'b00;
        rst1 = 1'b1; start1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst/ab", {a, b}, 0);
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/err_cnt", err_cnt, 0);
        chk("rst/err_flag", err_flag, 0);
        chk("rst/first", first_err_vec, 0);
        chk("rst1/busy", busy1, 0);
        rst = 1'b0;
        rst1 = 1'b0;

        // Directed sweeps
        sweep("clean", 2'b00, 2'b00, 5, 1'b0);
        sweep("z_zero", 2'b11, 2'b00, 2, 1'b0);
        sweep("z1_stuck1", 2'b00, 2'b10, 3, 1'b0);
        sweep("extra_start", 2'b00, 2'b00, 1, 1'b1);
        sweep("restart", 2'b00, 2'b00, 2, 1'b0);

        // Reset in the middle of vector 3 with errors already counted
        sa0 = 2'b00; sa1 = 2'b01;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (35) @(negedge clk);
        chk("midrst/pre_ab", {a, b}, 3);
        chk("midrst/pre_cnt", err_cnt, 3);
        #2 rst = 1'b1;
        #1;
        chk("midrst/ab", {a, b}, 0);
        chk("midrst/busy", busy, 0);
        chk("midrst/err_cnt", err_cnt, 0);
        chk("midrst/err_flag", err_flag, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst/no_done", done, 0);
        end
        // start together with reset: reset wins
        start = 1'b1;
        @(negedge clk);
        chk("rst_start/busy", busy, 0);
        start = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst/done", done, 0);
            chk("post_rst/busy", busy, 0);
        end
        sweep("after_rst", 2'b00, 2'b00, 1, 1'b0);

        // Randomized fault masks and start delays
        for (int r = 0; r < 4; r++) begin
            sweep("random", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end

        // HOLD=1: one vector per cycle
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("hold1/busy", busy1, 1);
            chk("hold1/ab", {a1, b1}, i);
            @(negedge clk);
        end
        chk("hold1/busy_end", busy1, 0);
        chk("hold1/done", done1, 1);
        chk("hold1/err_cnt", err_cnt1, 0);
        chk("hold1/err_flag", err_flag1, 0);
        @(negedge clk);
        chk("hold1/done_low", done1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
